// File: rtl/ysyx_22040386_idu_stage.sv
`default_nettype none
// ============================================================================
// ysyx_22040386_idu_stage : registered RV32I/RV64I decode stage with regfile,
// valid/ready ID/EX register, load-use bubble, flush and write-first WB bypass.
// Revision: 1.0
// ============================================================================
module ysyx_22040386_idu_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            i_ID_clk,
    input  logic            i_ID_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_imm,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic [4:0]      o_rd_addr,
    output logic            o_reg_write,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_alub_src,
    output logic            o_auipc,
    output logic            o_jal,
    output logic            o_jalr,
    output logic            o_lui,
    output logic            o_word_op,
    output logic [2:0]      o_branch_type,
    output logic [2:0]      o_mem_mask,
    output logic [2:0]      o_funct3,
    output logic [6:0]      o_funct7,
    output logic [1:0]      o_alu_op,
    output logic            o_illegal,
    output logic            o_load_use
);
    localparam int RW = $clog2(NREG);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM32  = 7'h1B;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_REG32  = 7'h3B;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign rs1    = i_inst[19:15];
    assign rs2    = i_inst[24:20];
    assign rd     = i_inst[11:7];

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_opimm, is_opimm32, is_op, is_op32;

    assign is_lui     = (opcode == OP_LUI);
    assign is_auipc   = (opcode == OP_AUIPC);
    assign is_jal     = (opcode == OP_JAL);
    assign is_jalr    = (opcode == OP_JALR);
    assign is_branch  = (opcode == OP_BRANCH);
    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign is_opimm   = (opcode == OP_IMM);
    assign is_opimm32 = (opcode == OP_IMM32);
    assign is_op      = (opcode == OP_REG);
    assign is_op32    = (opcode == OP_REG32);

    logic known, jalr_ok, word_class, uses_rs1, uses_rs2, reg_write_raw, bad_reg, illegal;
    logic alub_src;
    logic [1:0] alu_op;

    assign known = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store
                 | is_opimm | is_opimm32 | is_op | is_op32;
    assign jalr_ok    = is_jalr && (funct3 == 3'b000);
    assign word_class = is_opimm32 | is_op32;
    assign uses_rs1   = !(is_lui || is_auipc || is_jal);
    assign uses_rs2   = is_op | is_op32 | is_store | is_branch;
    assign reg_write_raw = is_op | is_op32 | is_opimm | is_opimm32 | is_load
                         | jalr_ok | is_jal | is_lui | is_auipc;
    assign alub_src   = is_lui | is_auipc | is_store | is_opimm | is_opimm32 | is_load | is_jalr;

    // Only register fields the instruction actually uses can make it illegal.
    assign bad_reg = (uses_rs1 && (int'(rs1) >= NREG))
                   | (uses_rs2 && (int'(rs2) >= NREG))
                   | (reg_write_raw && (int'(rd) >= NREG));
    assign illegal = !known || (is_jalr && (funct3 != 3'b000))
                   || ((XLEN == 32) && word_class) || bad_reg;

    always_comb begin
        alu_op = 2'b00;
        if (is_op || is_op32)           alu_op = 2'b10;
        else if (is_opimm || is_opimm32) alu_op = 2'b01;
        else if (is_branch)             alu_op = 2'b11;
    end

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm32 = 32'd0;
        if (is_opimm || is_opimm32 || is_load || is_jalr)
            imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        else if (is_store)
            imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        else if (is_branch)
            imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        else if (is_jal)
            imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
        else if (is_lui || is_auipc)
            imm32 = {i_inst[31:12], 12'd0};
        imm        = {XLEN{imm32[31]}};
        imm[31:0]  = imm32;
    end

    logic [XLEN-1:0] rf [NREG];

    always_ff @(posedge i_ID_clk or posedge i_ID_rst) begin
        if (i_ID_rst) begin
            for (int k = 0; k < NREG; k++) rf[k] <= '0;
        end else if (i_wb_en && (i_wb_addr != 5'd0) && (int'(i_wb_addr) < NREG)) begin
            rf[i_wb_addr[RW-1:0]] <= i_wb_data;
        end
    end

    // Write-first: a same-cycle WB to the read index wins over the stored value.
    logic [XLEN-1:0] rs1_data, rs2_data;

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if ((rs1 != 5'd0) && (int'(rs1) < NREG))
            rs1_data = (i_wb_en && (i_wb_addr == rs1)) ? i_wb_data : rf[rs1[RW-1:0]];
        if ((rs2 != 5'd0) && (int'(rs2) < NREG))
            rs2_data = (i_wb_en && (i_wb_addr == rs2)) ? i_wb_data : rf[rs2[RW-1:0]];
    end

    logic load_use, adv, fire;

    assign load_use = i_valid && o_valid && o_mem_read && (o_rd_addr != 5'd0)
                   && ((uses_rs1 && (rs1 == o_rd_addr)) || (uses_rs2 && (rs2 == o_rd_addr)));
    assign adv        = !o_valid || i_ready;
    assign o_ready    = adv && !i_flush && !load_use;
    assign fire       = i_valid && o_ready;
    assign o_load_use = load_use;

    always_ff @(posedge i_ID_clk or posedge i_ID_rst) begin
        if (i_ID_rst) begin
            o_valid       <= 1'b0;
            o_pc          <= '0;
            o_imm         <= '0;
            o_inst        <= '0;
            o_rs1_data    <= '0;
            o_rs2_data    <= '0;
            o_rs1_addr    <= '0;
            o_rs2_addr    <= '0;
            o_rd_addr     <= '0;
            o_reg_write   <= 1'b0;
            o_mem_read    <= 1'b0;
            o_mem_write   <= 1'b0;
            o_alub_src    <= 1'b0;
            o_auipc       <= 1'b0;
            o_jal         <= 1'b0;
            o_jalr        <= 1'b0;
            o_lui         <= 1'b0;
            o_word_op     <= 1'b0;
            o_branch_type <= '0;
            o_mem_mask    <= '0;
            o_funct3      <= '0;
            o_funct7      <= '0;
            o_alu_op      <= '0;
            o_illegal     <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (adv) begin
            o_valid <= fire;
            if (fire) begin
                o_pc          <= i_pc;
                o_imm         <= imm;
                o_inst        <= i_inst;
                o_rs1_data    <= rs1_data;
                o_rs2_data    <= rs2_data;
                o_rs1_addr    <= rs1;
                o_rs2_addr    <= rs2;
                o_rd_addr     <= rd;
                o_reg_write   <= reg_write_raw && !illegal;
                o_mem_read    <= is_load && !illegal;
                o_mem_write   <= is_store && !illegal;
                o_alub_src    <= alub_src;
                o_auipc       <= is_auipc;
                o_jal         <= is_jal;
                o_jalr        <= jalr_ok;
                o_lui         <= is_lui;
                o_word_op     <= (XLEN == 64) ? i_inst[3] : 1'b0;
                o_branch_type <= is_branch ? funct3 : 3'b010;
                o_mem_mask    <= funct3;
                o_funct3      <= funct3;
                o_funct7      <= i_inst[31:25];
                o_alu_op      <= alu_op;
                o_illegal     <= illegal;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040386_idu_stage.sv
`default_nettype none
// ============================================================================
// tb_ysyx_22040386_idu_stage : directed + randomized bench with a behavioural
// decode/pipeline model. Revision: 1.0
// ============================================================================
module tb_ysyx_22040386_idu_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance (XLEN=64, NREG=32)
    logic        i_flush, i_valid, i_ready, i_wb_en;
    logic [63:0] i_pc, i_wb_data;
    logic [31:0] i_inst;
    logic [4:0]  i_wb_addr;
    logic        o_ready, o_valid, o_reg_write, o_mem_read, o_mem_write, o_alub_src;
    logic        o_auipc, o_jal, o_jalr, o_lui, o_word_op, o_illegal, o_load_use;
    logic [63:0] o_pc, o_imm, o_rs1_data, o_rs2_data;
    logic [31:0] o_inst;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [2:0]  o_branch_type, o_mem_mask, o_funct3;
    logic [6:0]  o_funct7;
    logic [1:0]  o_alu_op;

    ysyx_22040386_idu_stage #(.XLEN(64), .NREG(32)) dut (
        .i_ID_clk(clk), .i_ID_rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_inst(i_inst), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_imm(o_imm), .o_inst(o_inst),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_rs1_addr(o_rs1_addr),
        .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_alub_src(o_alub_src),
        .o_auipc(o_auipc), .o_jal(o_jal), .o_jalr(o_jalr), .o_lui(o_lui), .o_word_op(o_word_op),
        .o_branch_type(o_branch_type), .o_mem_mask(o_mem_mask), .o_funct3(o_funct3),
        .o_funct7(o_funct7), .o_alu_op(o_alu_op), .o_illegal(o_illegal), .o_load_use(o_load_use)
    );

    // narrow instance (XLEN=32, NREG=16)
    logic        v2;
    logic [31:0] inst2;
    logic        o_ready2, o_valid2, o_reg_write2, o_mem_read2, o_mem_write2, o_alub_src2;
    logic        o_auipc2, o_jal2, o_jalr2, o_lui2, o_word_op2, o_illegal2, o_load_use2;
    logic [31:0] o_pc2, o_imm2, o_rs1_data2, o_rs2_data2, o_inst2;
    logic [4:0]  o_rs1_addr2, o_rs2_addr2, o_rd_addr2;
    logic [2:0]  o_branch_type2, o_mem_mask2, o_funct32;
    logic [6:0]  o_funct72;
    logic [1:0]  o_alu_op2;

    ysyx_22040386_idu_stage #(.XLEN(32), .NREG(16)) dut2 (
        .i_ID_clk(clk), .i_ID_rst(rst), .i_flush(1'b0), .i_valid(v2), .o_ready(o_ready2),
        .i_pc(32'h100), .i_inst(inst2), .i_wb_en(1'b0), .i_wb_addr(5'd0), .i_wb_data(32'd0),
        .o_valid(o_valid2), .i_ready(1'b1), .o_pc(o_pc2), .o_imm(o_imm2), .o_inst(o_inst2),
        .o_rs1_data(o_rs1_data2), .o_rs2_data(o_rs2_data2), .o_rs1_addr(o_rs1_addr2),
        .o_rs2_addr(o_rs2_addr2), .o_rd_addr(o_rd_addr2), .o_reg_write(o_reg_write2),
        .o_mem_read(o_mem_read2), .o_mem_write(o_mem_write2), .o_alub_src(o_alub_src2),
        .o_auipc(o_auipc2), .o_jal(o_jal2), .o_jalr(o_jalr2), .o_lui(o_lui2), .o_word_op(o_word_op2),
        .o_branch_type(o_branch_type2), .o_mem_mask(o_mem_mask2), .o_funct3(o_funct32),
        .o_funct7(o_funct72), .o_alu_op(o_alu_op2), .o_illegal(o_illegal2), .o_load_use(o_load_use2)
    );

    typedef struct packed {
        logic [63:0] pc, imm, rs1d, rs2d;
        logic [31:0] inst;
        logic [4:0]  rs1a, rs2a, rd;
        logic        rw, mr, mw, alub, auipc, jal, jalr, lui, wop, ill;
        logic [2:0]  br, mask, f3;
        logic [6:0]  f7;
        logic [1:0]  aluop;
    } entry_t;

    entry_t      m;
    bit          mv;
    logic [63:0] mrf [32];
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (i_wb_en && i_wb_addr == a) return i_wb_data;
        return mrf[a];
    endfunction

    // Reference decode written from the ISA format tables.
    function automatic entry_t model_decode(input logic [31:0] i, input logic [63:0] p);
        entry_t e;
        logic [2:0] f3;
        f3 = i[14:12];
        e = '0;
        e.pc = p; e.inst = i;
        e.rs1a = i[19:15]; e.rs2a = i[24:20]; e.rd = i[11:7];
        e.rs1d = mread(i[19:15]); e.rs2d = mread(i[24:20]);
        e.wop = i[3]; e.br = 3'b010; e.mask = f3; e.f3 = f3; e.f7 = i[31:25];
        case (i[6:0])
            7'h37: begin e.lui = 1; e.rw = 1; e.alub = 1; e.imm = 64'($signed({i[31:12], 12'h0})); end
            7'h17: begin e.auipc = 1; e.rw = 1; e.alub = 1; e.imm = 64'($signed({i[31:12], 12'h0})); end
            7'h6F: begin e.jal = 1; e.rw = 1;
                         e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h67: begin e.alub = 1; e.imm = 64'($signed(i[31:20]));
                         if (f3 == 3'b000) begin e.jalr = 1; e.rw = 1; end else e.ill = 1; end
            7'h63: begin e.br = f3; e.aluop = 2'b11;
                         e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h03: begin e.mr = 1; e.rw = 1; e.alub = 1; e.imm = 64'($signed(i[31:20])); end
            7'h23: begin e.mw = 1; e.alub = 1; e.imm = 64'($signed({i[31:25], i[11:7]})); end
            7'h13, 7'h1B: begin e.rw = 1; e.alub = 1; e.aluop = 2'b01; e.imm = 64'($signed(i[31:20])); end
            7'h33, 7'h3B: begin e.rw = 1; e.aluop = 2'b10; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.rw = 0; e.mr = 0; e.mw = 0; end
        return e;
    endfunction

    task automatic check_regs();
        chk("valid", o_valid, mv);
        chk("pc", o_pc, m.pc);
        chk("inst", o_inst, m.inst);
        chk("imm", o_imm, m.imm);
        chk("rs1_data", o_rs1_data, m.rs1d);
        chk("rs2_data", o_rs2_data, m.rs2d);
        chk("addrs", {o_rs1_addr, o_rs2_addr, o_rd_addr}, {m.rs1a, m.rs2a, m.rd});
        chk("ctl", {o_reg_write, o_mem_read, o_mem_write, o_alub_src, o_auipc, o_jal, o_jalr, o_lui,
                    o_word_op, o_illegal},
                   {m.rw, m.mr, m.mw, m.alub, m.auipc, m.jal, m.jalr, m.lui, m.wop, m.ill});
        chk("misc", {o_branch_type, o_mem_mask, o_funct3, o_funct7, o_alu_op},
                    {m.br, m.mask, m.f3, m.f7, m.aluop});
    endtask

    // One clock: check mid-cycle, then advance the model across the edge.
    task automatic step();
        bit u1, u2, lu, adv, rdy;
        u1  = !(i_inst[6:0] inside {7'h37, 7'h17, 7'h6F});
        u2  = i_inst[6:0] inside {7'h33, 7'h3B, 7'h23, 7'h63};
        lu  = i_valid && mv && m.mr && (m.rd != 0)
           && ((u1 && i_inst[19:15] == m.rd) || (u2 && i_inst[24:20] == m.rd));
        adv = !mv || i_ready;
        rdy = adv && !i_flush && !lu;
        #3;
        check_regs();
        chk("ready", o_ready, rdy);
        chk("load_use", o_load_use, lu);
        @(posedge clk);
        if (i_flush) mv = 0;
        else if (adv) begin
            if (i_valid && rdy) begin m = model_decode(i_inst, i_pc); mv = 1; end
            else mv = 0;
        end
        if (i_wb_en && i_wb_addr != 0) mrf[i_wb_addr] = i_wb_data;
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                         input logic rdy, input logic fl);
        i_valid = v; i_inst = ins; i_pc = p; i_ready = rdy; i_flush = fl;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [63:0] d);
        i_wb_en = en; i_wb_addr = a; i_wb_data = d;
    endtask

    task automatic model_reset();
        m = '0; mv = 0;
        for (int k = 0; k < 32; k++) mrf[k] = 64'd0;
    endtask

    localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B};

    initial begin
        logic [31:0] t6_inst [4];
        logic [1:0]  t6_exp  [4];
        logic [31:0] ri;

        rst = 1'b1;
        drive(0, 32'd0, 64'd0, 1, 0);
        wb(0, 5'd0, 64'd0);
        v2 = 1'b0; inst2 = 32'd0;
        model_reset();
        #12;
        check_regs();
        chk("reset_ready", o_ready, 1'b1);
        chk("reset_valid2", o_valid2, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // addi x1,x0,5
        drive(1, 32'h00500093, 64'h8000_0000, 1, 0);
        step();
        chk("t1_valid", o_valid, 1'b1);
        chk("t1_imm", o_imm, 64'd5);
        chk("t1_reg_write", o_reg_write, 1'b1);
        chk("t1_alu_op", o_alu_op, 2'b01);

        // ld x2,0(x1) then add x3,x2,x1
        drive(1, 32'h0000B103, 64'h8000_0004, 1, 0);
        step();
        drive(1, 32'h001101B3, 64'h8000_0008, 1, 0);
        #2;
        chk("t2_load_use", o_load_use, 1'b1);
        chk("t2_ready", o_ready, 1'b0);
        step();
        chk("t2_bubble", o_valid, 1'b0);
        step();
        chk("t2_add_valid", o_valid, 1'b1);
        chk("t2_add_inst", o_inst, 32'h001101B3);

        // stall three cycles with a pending instruction
        drive(1, 32'h00028313, 64'h8000_000C, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_hold", o_inst, 32'h001101B3);
            chk("t3_ready", o_ready, 1'b0);
        end
        i_ready = 1'b1;
        step();
        chk("t3_no_loss", o_inst, 32'h00028313);

        // write-first bypass, and x0 stays zero
        wb(1, 5'd5, 64'hDEAD);
        drive(1, 32'h00028313, 64'h8000_0010, 1, 0);
        step();
        chk("t4_bypass", o_rs1_data, 64'hDEAD);
        wb(1, 5'd0, 64'hFFFF);
        drive(1, 32'h00000313, 64'h8000_0014, 1, 0);
        step();
        chk("t4_x0", o_rs1_data, 64'd0);
        wb(0, 5'd0, 64'd0);

        // flush kills entry and incoming instruction
        drive(1, 32'h00500093, 64'h8000_0018, 1, 1);
        #2;
        chk("t5_ready", o_ready, 1'b0);
        step();
        chk("t5_valid", o_valid, 1'b0);
        drive(0, 32'd0, 64'd0, 1, 0);

        // narrow instance: addiw, add x17, addi, add x1,x17,x2
        t6_inst = '{32'h0010009B, 32'h002088B3, 32'h00500093, 32'h002880B3};
        t6_exp  = '{2'b10, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 4; k++) begin
            v2 = 1'b1; inst2 = t6_inst[k];
            step();
            chk("t6_valid2", o_valid2, 1'b1);
            chk("t6_illegal_rw", {o_illegal2, o_reg_write2}, t6_exp[k]);
        end
        chk("t6_imm2", o_imm2, 64'd0);
        v2 = 1'b0;

        // reset in the middle of a stall
        drive(1, 32'h00500093, 64'h8000_0020, 1, 0);
        step();
        drive(1, 32'h00A00113, 64'h8000_0024, 0, 0);
        step();
        rst = 1'b1;
        #1;
        chk("rst_async_valid", o_valid, 1'b0);
        chk("rst_async_inst", o_inst, 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
        drive(0, 32'd0, 64'd0, 1, 0);
        step();

        // randomized traffic with small register indices to provoke hazards
        for (int n = 0; n < 500; n++) begin
            ri = $urandom;
            ri[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 10)];
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            ri[11:7]  = 5'($urandom_range(0, 3));
            if (ri[6:0] == 7'h67 && $urandom_range(0, 3) != 0) ri[14:12] = 3'b000;
            drive($urandom_range(0, 9) < 7, ri, {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), {$urandom, $urandom});
            step();
        end
        drive(0, 32'd0, 64'd0, 1, 0);
        wb(0, 5'd0, 64'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
